fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter sharing one 8-bit FIFO write port between several producers. It sits in front of the FIFO memory block and drives the FIFO's `wr`/`data_in` from one granted requester at a time. It honours the FIFO's `fifo_full` flag, so the FIFO never sees a write while full and never raises overflow because of this block. Each grant is a burst of up to MAX_BURST beats, which bounds latency for the other requesters.

---
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one FIFO write port between NUM_REQ producers.
// Each grant is a burst of up to MAX_BURST beats; writes are held off while fifo_full is high.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic                       fifo_full,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       wr,
   output logic [DATA_W-1:0]          data_out,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
   localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state;
   logic [BW-1:0]   beat_cnt;
   logic [OW-1:0]   last_owner;
   logic [OW-1:0]   search_base;
   logic [OW-1:0]   cand;
   logic [OW-1:0]   winner;
   logic            found;
   logic            release_now;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // Search starts just past the previous owner, so that owner is considered last.
   assign search_base = (state == GRANT) ? owner : last_owner;

   always_comb begin
      // NOTE: every variable gets a default first so no path through the loop infers a latch.
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = OW'((int'(search_base) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Gating with rst_n keeps the reset cycle itself from issuing a write.
   assign wr          = busy && rst_n && req[owner] && !fifo_full;
   assign data_out    = busy ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
   assign release_now = !req[owner] || (wr && (beat_cnt == LAST_BEAT));

   always_comb begin
      ack = '0;
      if (wr) ack[owner] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= '0;
         owner      <= '0;
         busy       <= 1'b0;
         beat_cnt   <= '0;
         last_owner <= LAST_IDX;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  state    <= GRANT;
                  busy     <= 1'b1;
                  owner    <= winner;
                  gnt      <= onehot(winner);
                  beat_cnt <= '0;
               end
            end
            GRANT: begin
               if (release_now) begin
                  last_owner <= owner;
                  beat_cnt   <= '0;
                  if (found) begin
                     owner <= winner;
                     gnt   <= onehot(winner);
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     gnt   <= '0;
                  end
               end else if (wr) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a MAX_BURST=4 instance for most scenarios and a
// MAX_BURST=1 instance for single-beat alternation. Inputs change at posedge+1, outputs sampled at negedge.
module tb_fifo_wr_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req, gnt, ack;
   logic [N*W-1:0] req_data;
   logic           fifo_full, wr, busy;
   logic [W-1:0]   data_out;
   logic [1:0]     owner;

   logic [N-1:0]   req_b, gnt_b, ack_b;
   logic [N*W-1:0] req_data_b;
   logic           fifo_full_b, wr_b, busy_b;
   logic [W-1:0]   data_out_b;
   logic [1:0]     owner_b;

   int checks = 0;
   int errors = 0;
   int cnt   [N];
   int cnt_b [N];

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .fifo_full(fifo_full),
      .gnt(gnt), .ack(ack), .wr(wr), .data_out(data_out), .owner(owner), .busy(busy)
   );

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .req_data(req_data_b), .fifo_full(fifo_full_b),
      .gnt(gnt_b), .ack(ack_b), .wr(wr_b), .data_out(data_out_b), .owner(owner_b), .busy(busy_b)
   );

   // Requester i sends 0x(i+1)0 + beat index: requester 0 sends 0x10, 0x11, ...
   function automatic logic [W-1:0] val(input int i, input int k);
      return W'((i + 1) * 16 + k);
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_data[i*W +: W]   = val(i, cnt[i]);
         req_data_b[i*W +: W] = val(i, cnt_b[i]);
      end
   endtask

   // Producers advance their data only after an ack, then the next cycle begins.
   task automatic next_cycle();
      for (int i = 0; i < N; i++) begin
         if (ack[i])   cnt[i]++;
         if (ack_b[i]) cnt_b[i]++;
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req = '0; req_b = '0; fifo_full = 1'b0; fifo_full_b = 1'b0;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; cnt_b[i] = 0; end
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = '1; req_b = '1; fifo_full = 1'b0; fifo_full_b = 1'b0;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; cnt_b[i] = 0; end
      drive();
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
      checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", wr); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d exp=0", owner); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (gnt_b !== 4'b0000) begin errors++; $display("FAIL reset_gnt_b got=%b exp=0000", gnt_b); end
      req = '0; req_b = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Sole requester 0: 4-beat burst, immediate re-grant, two more beats, then req drops.
   task automatic test_single_burst();
      apply_reset();
      for (int c = 0; c <= 8; c++) begin
         req = (c <= 6) ? 4'b0001 : 4'b0000;
         @(negedge clk);
         if (c == 0 || c == 8) begin
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt c=%0d got=%b exp=0000", c, gnt); end
            checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_idle_wr c=%0d got=%b exp=0", c, wr); end
         end else if (c == 7) begin
            checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_drop_wr got=%b exp=0", wr); end
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_drop_gnt got=%b exp=0001", gnt); end
         end else begin
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt c=%0d got=%b exp=0001", c, gnt); end
            checks++; if (ack !== 4'b0001 || wr !== 1'b1) begin errors++; $display("FAIL single_ack c=%0d got ack=%b wr=%b exp ack=0001 wr=1", c, ack, wr); end
            checks++; if (data_out !== W'(8'h10 + c - 1)) begin errors++; $display("FAIL single_data c=%0d got=%h exp=%h", c, data_out, W'(8'h10 + c - 1)); end
         end
         next_cycle();
      end
   endtask

   // All four requesting: owners 0,1,2,3,0 with four beats each and no gaps.
   task automatic test_rotation();
      apply_reset();
      req = 4'b1111;
      drive();
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rot_idle_gnt got=%b exp=0000", gnt); end
      next_cycle();
      for (int c = 1; c <= 20; c++) begin
         int k, o, b;
         k = c - 1;
         o = (k / 4) % 4;
         b = (k % 4) + 4 * (k / 16);
         @(negedge clk);
         checks++; if (gnt !== 4'(1 << o)) begin errors++; $display("FAIL rot_gnt c=%0d got=%b exp=%b", c, gnt, 4'(1 << o)); end
         checks++; if (ack !== gnt || wr !== 1'b1) begin errors++; $display("FAIL rot_ack c=%0d got ack=%b wr=%b exp ack=%b wr=1", c, ack, wr, gnt); end
         checks++; if (owner !== 2'(o)) begin errors++; $display("FAIL rot_owner c=%0d got=%0d exp=%0d", c, owner, o); end
         checks++; if (data_out !== val(o, b)) begin errors++; $display("FAIL rot_data c=%0d got=%h exp=%h", c, data_out, val(o, b)); end
         next_cycle();
      end
      req = 4'b0000;
      next_cycle();
   endtask

   // Requester 2 stalled by fifo_full for 3 cycles after two beats; burst still totals 4 beats.
   task automatic test_fifo_stall();
      logic [8:0] exp_wr   = 9'b011000110;
      logic [8:0] full_pat = 9'b000111000;
      int nb = 0;
      int seen = 0;
      apply_reset();
      for (int c = 0; c <= 8; c++) begin
         req       = (c <= 7) ? 4'b0100 : 4'b0000;
         fifo_full = full_pat[c];
         @(negedge clk);
         checks++; if (gnt !== ((c == 0) ? 4'b0000 : 4'b0100)) begin errors++; $display("FAIL stall_gnt c=%0d got=%b exp=%b", c, gnt, (c == 0) ? 4'b0000 : 4'b0100); end
         checks++; if (wr !== exp_wr[c] || ack !== (exp_wr[c] ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL stall_wr c=%0d got wr=%b ack=%b exp wr=%b", c, wr, ack, exp_wr[c]); end
         if (exp_wr[c]) begin
            checks++; if (data_out !== val(2, nb)) begin errors++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, data_out, val(2, nb)); end
            nb++;
         end
         if (ack[2]) seen++;
         next_cycle();
      end
      fifo_full = 1'b0;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL stall_end got gnt=%b busy=%b exp gnt=0000 busy=0", gnt, busy); end
      checks++; if (seen !== 4) begin errors++; $display("FAIL stall_beats got=%0d exp=4", seen); end
   endtask

   // Requester 1 drops req after two beats while requester 3 waits: one dead cycle, then gnt=1000.
   task automatic test_req_drop();
      logic [3:0] req_v [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000};
      logic [3:0] gnt_v [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
      logic [3:0] ack_v [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
      logic [7:0] dat_v [6] = '{8'h00, 8'h20, 8'h21, 8'h00, 8'h40, 8'h00};
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         req = req_v[c];
         @(negedge clk);
         checks++; if (gnt !== gnt_v[c]) begin errors++; $display("FAIL drop_gnt c=%0d got=%b exp=%b", c, gnt, gnt_v[c]); end
         checks++; if (ack !== ack_v[c] || wr !== (ack_v[c] != 4'b0000)) begin errors++; $display("FAIL drop_ack c=%0d got ack=%b wr=%b exp ack=%b", c, ack, wr, ack_v[c]); end
         if (ack_v[c] != 4'b0000) begin
            checks++; if (data_out !== dat_v[c]) begin errors++; $display("FAIL drop_data c=%0d got=%h exp=%h", c, data_out, dat_v[c]); end
         end
         if (c == 4) begin
            checks++; if (owner !== 2'd3) begin errors++; $display("FAIL drop_owner got=%0d exp=3", owner); end
         end
         next_cycle();
      end
   endtask

   // Reset pulse in the middle of requester 3's burst; afterwards requester 0 wins first.
   task automatic test_mid_reset();
      apply_reset();
      for (int c = 0; c <= 5; c++) begin
         rst_n = (c == 3) ? 1'b0 : 1'b1;
         req   = (c >= 4) ? 4'b1111 : 4'b1000;
         @(negedge clk);
         if (c == 1 || c == 2) begin
            checks++; if (gnt !== 4'b1000 || wr !== 1'b1) begin errors++; $display("FAIL mrst_burst c=%0d got gnt=%b wr=%b exp gnt=1000 wr=1", c, gnt, wr); end
         end
         if (c == 3) begin
            checks++; if (wr !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL mrst_cycle got wr=%b ack=%b exp wr=0 ack=0000", wr, ack); end
         end
         if (c == 4) begin
            checks++; if (gnt !== 4'b0000 || wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_after got gnt=%b wr=%b busy=%b exp 0000/0/0", gnt, wr, busy); end
         end
         if (c == 5) begin
            checks++; if (gnt !== 4'b0001 || owner !== 2'd0) begin errors++; $display("FAIL mrst_first got gnt=%b owner=%0d exp gnt=0001 owner=0", gnt, owner); end
            checks++; if (wr !== 1'b1 || data_out !== 8'h10) begin errors++; $display("FAIL mrst_data got wr=%b data=%h exp wr=1 data=10", wr, data_out); end
         end
         next_cycle();
      end
      req = 4'b0000;
      next_cycle();
   endtask

   // MAX_BURST=1 instance with requesters 0 and 2: strict alternation, 8 writes, none lost or repeated.
   task automatic test_burst_one();
      int writes = 0;
      apply_reset();
      req_b = 4'b0101;
      drive();
      @(negedge clk);
      checks++; if (gnt_b !== 4'b0000) begin errors++; $display("FAIL b1_idle_gnt got=%b exp=0000", gnt_b); end
      next_cycle();
      for (int c = 1; c <= 8; c++) begin
         int k, o;
         k = c - 1;
         o = (k % 2 == 0) ? 0 : 2;
         @(negedge clk);
         checks++; if (gnt_b !== 4'(1 << o) || ack_b !== 4'(1 << o)) begin errors++; $display("FAIL b1_gnt c=%0d got gnt=%b ack=%b exp=%b", c, gnt_b, ack_b, 4'(1 << o)); end
         checks++; if (data_out_b !== val(o, k / 2)) begin errors++; $display("FAIL b1_data c=%0d got=%h exp=%h", c, data_out_b, val(o, k / 2)); end
         if (wr_b) writes++;
         next_cycle();
      end
      checks++; if (writes !== 8) begin errors++; $display("FAIL b1_writes got=%0d exp=8", writes); end
      req_b = 4'b0000;
      next_cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0; req_b = '0; fifo_full = 1'b0; fifo_full_b = 1'b0;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; cnt_b[i] = 0; end
      drive();
      test_reset();
      test_single_burst();
      test_rotation();
      test_fifo_stall();
      test_req_drop();
      test_mid_reset();
      test_burst_one();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
